// File: rtl/wb_commit_queue.sv
// wb_commit_queue
//
// Writeback commit queue between the writeback-stage result sources and the
// register file write port. Holds up to DEPTH register writes in program
// order and drains the oldest one into the register file each cycle unless
// writeback is stalled. A combinational lookup lets decode read values that
// are still waiting in the queue.
//
// Parameters
//   DEPTH  queue entries (power of two, 2..16)
//   CNTW   width of the occupancy count
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     producer handshake for a write to commit
//   in_waddr, in_wdata    destination register and result value
//   stallW                writeback stalled, hold the head entry
//   we3, wa3, wd3         register file write port (head entry)
//   q_ra                  forwarding lookup address
//   q_hit, q_data         youngest pending write to q_ra
//   count, full, empty    occupancy status
//
// Handshake: a write transfers on every rising edge where in_valid and
// in_ready are both high. in_ready depends only on state (it is ~full), so a
// producer may hold in_valid and its payload until it sees in_ready.
//
// Optional feature: define WBQ_INPUT_FWD_EN to let the lookup also see the
// write being pushed this cycle, with priority over stored entries.

module wb_commit_queue #(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_waddr,
  input  logic [31:0]     in_wdata,
  input  logic            stallW,
  output logic            we3,
  output logic [4:0]      wa3,
  output logic [31:0]     wd3,
  input  logic [4:0]      q_ra,
  output logic            q_hit,
  output logic [31:0]     q_data,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]      waddr_mem [DEPTH];
  logic [31:0]     wdata_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CNTW-1:0] count_q;

  logic            push;
  logic            store;
  logic            pop;
  logic [PW-1:0]   idx;

  assign full     = (count_q == CNTW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = ~full;

  // r0 writes complete the handshake but are dropped: the register file
  // ignores them anyway and they must never shadow a real value.
  assign push  = in_valid & in_ready;
  assign store = push & (in_waddr != 5'd0);
  assign pop   = ~empty & ~stallW;

  assign we3 = ~empty;
  assign wa3 = empty ? 5'd0  : waddr_mem[head];
  assign wd3 = empty ? 32'd0 : wdata_mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (store) tail <= tail + PW'(1);
      if (pop)   head <= head + PW'(1);
      if (store && !pop)      count_q <= count_q + CNTW'(1);
      else if (!store && pop) count_q <= count_q - CNTW'(1);
    end
  end

  // Payload storage needs no reset: nothing reads a slot before it is
  // written, because outputs and lookup are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (store) begin
      waddr_mem[tail] <= in_waddr;
      wdata_mem[tail] <= in_wdata;
    end
  end

  // Walk entries oldest to youngest so the last match wins. The head entry
  // still counts even when it is draining this cycle, since the register
  // file only sees it at the coming edge.
  always_comb begin
    q_hit  = 1'b0;
    q_data = 32'd0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CNTW'(i) < count_q) && (q_ra != 5'd0) && (waddr_mem[idx] == q_ra)) begin
        q_hit  = 1'b1;
        q_data = wdata_mem[idx];
      end
    end
`ifdef WBQ_INPUT_FWD_EN
    if (push && (q_ra != 5'd0) && (in_waddr == q_ra)) begin
      q_hit  = 1'b1;
      q_data = in_wdata;
    end
`else
    // Incoming write becomes visible once stored, on the next cycle.
`endif
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;

  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_waddr;
  logic [31:0]     in_wdata;
  logic            stallW;
  logic            we3;
  logic [4:0]      wa3;
  logic [31:0]     wd3;
  logic [4:0]      q_ra;
  logic            q_hit;
  logic [31:0]     q_data;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;

  int errors = 0;
  int checks = 0;

  wb_commit_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_waddr (in_waddr),
    .in_wdata (in_wdata),
    .stallW   (stallW),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .q_ra     (q_ra),
    .q_hit    (q_hit),
    .q_data   (q_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // clock
  always #5 clk = ~clk;

  // advance one rising edge; inputs are driven and outputs sampled 1 time
  // unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_waddr = a;
    in_wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_we3"},      32'(we3),      32'd0);
    chk({tag, "_wa3"},      32'(wa3),      32'd0);
    chk({tag, "_wd3"},      32'(wd3),      32'd0);
    chk({tag, "_q_hit"},    32'(q_hit),    32'd0);
    chk({tag, "_q_data"},   q_data,        32'd0);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    stallW = 1'b0;
    q_ra = 5'd0;
    drive(1'b0, 5'd0, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    q_ra = 5'd5;
    #1;
    chk_reset_state("reset");
    cyc();
    chk_reset_state("idle");

    // single push r5 then drain next cycle
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("single_we3",   32'(we3),   32'd1);
    chk("single_wa3",   32'(wa3),   32'd5);
    chk("single_wd3",   wd3,        32'hDEADBEEF);
    chk("single_count", 32'(count), 32'd1);
    chk("single_q_hit", 32'(q_hit), 32'd1);
    chk("single_q_data", q_data,    32'hDEADBEEF);
    cyc();
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_we3_off", 32'(we3), 32'd0);

    // stalled fill: 5 offered, 4 accepted, head held
    stallW = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(k + 1), 32'h100 + 32'(k + 1));
      #1;
      chk("fill_ready", 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("fill_head_wa3", 32'(wa3), 32'd1);
        chk("fill_head_wd3", wd3, 32'h101);
      end
      cyc();
    end
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready_low", 32'(in_ready), 32'd0);
    chk("fill_we3",   32'(we3),   32'd1);
    chk("fill_wa3",   32'(wa3),   32'd1);

    // release stall: drain in order; a push offered while full and popping
    // must be refused
    stallW = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j == 0) drive(1'b1, 5'd9, 32'h999);
      else        drive(1'b0, 5'd0, 32'd0);
      #1;
      if (j == 0) chk("drain_no_passthru", 32'(in_ready), 32'd0);
      chk("drain_we3", 32'(we3), 32'd1);
      chk("drain_wa3", 32'(wa3), 32'(j + 1));
      chk("drain_wd3", wd3, 32'h101 + 32'(j));
      cyc();
    end
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // r0 push: handshake completes, nothing stored
    drive(1'b1, 5'd0, 32'h1234);
    #1;
    chk("r0_ready", 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_we3",   32'(we3),   32'd0);

    // simultaneous push and pop keep count steady
    drive(1'b1, 5'd2, 32'h200);
    cyc();
    drive(1'b1, 5'd4, 32'h400);
    #1;
    chk("thru_wa3_r2", 32'(wa3), 32'd2);
    cyc();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("thru_count", 32'(count), 32'd1);
    chk("thru_wa3_r4", 32'(wa3), 32'd4);
    chk("thru_wd3_r4", wd3, 32'h400);
    cyc();
    chk("thru_empty", 32'(empty), 32'd1);

    // forwarding: youngest of two r7 writes wins
    stallW = 1'b1;
    drive(1'b1, 5'd7, 32'h11);
    cyc();
    drive(1'b1, 5'd7, 32'h22);
    cyc();
    drive(1'b0, 5'd0, 32'd0);
    q_ra = 5'd7;
    #1;
    chk("fwd_r7_hit",  32'(q_hit), 32'd1);
    chk("fwd_r7_data", q_data,     32'h22);
    q_ra = 5'd0;
    #1;
    chk("fwd_r0_hit",  32'(q_hit), 32'd0);
    chk("fwd_r0_data", q_data,     32'd0);
    q_ra = 5'd8;
    #1;
    chk("fwd_miss_hit", 32'(q_hit), 32'd0);

    // incoming-write forwarding
    drive(1'b1, 5'd3, 32'hA);
    cyc();
    drive(1'b1, 5'd3, 32'hB);
    q_ra = 5'd3;
    #1;
    chk("infwd_hit", 32'(q_hit), 32'd1);
`ifdef WBQ_INPUT_FWD_EN
    chk("infwd_same_cycle", q_data, 32'hB);
`else
    chk("infwd_same_cycle", q_data, 32'hA);
`endif
    cyc();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("infwd_next_cycle", q_data, 32'hB);
    chk("infwd_full", 32'(full), 32'd1);

    // drain: both r7 and both r3 writes, younger last
    stallW = 1'b0;
    chk("order0_wa3", 32'(wa3), 32'd7);
    chk("order0_wd3", wd3, 32'h11);
    cyc();
    chk("order1_wd3", wd3, 32'h22);
    cyc();
    chk("order2_wa3", 32'(wa3), 32'd3);
    chk("order2_wd3", wd3, 32'hA);
    cyc();
    chk("order3_wd3", wd3, 32'hB);
    cyc();
    chk("order_empty", 32'(empty), 32'd1);

    // reset mid-fill with three entries
    stallW = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(k + 1), 32'h50 + 32'(k));
      cyc();
    end
    drive(1'b0, 5'd0, 32'd0);
    q_ra = 5'd1;
    #1;
    chk("midrst_count_before", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    cyc();
    rst = 1'b0;
    stallW = 1'b0;
    cyc();
    chk_reset_state("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Writeback commit queue sitting between the writeback-stage result sources and the register file write port. Buffers up to DEPTH register writes (waddr, wdata) in program order and drains them into the register file one per cycle, holding while the writeback stage is stalled. Provides a forwarding lookup so decode can read values still pending in the queue.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- CNTW, $clog2(DEPTH)+1: width of the occupancy count.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a write to commit.
- in_ready  out  1  queue accepts; push = in_valid & in_ready.
- in_waddr  in  5  destination register.
- in_wdata  in  32  result value.
- stallW  in  1  writeback stalled; no drain this cycle.
- we3  out  1  register file write enable.
- wa3  out  5  register file write address.
- wd3  out  32  register file write data.
- q_ra  in  5  forwarding lookup address.
- q_hit  out  1  a pending write to q_ra exists.
- q_data  out  32  value of the youngest pending write to q_ra.
- count  out  CNTW  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Circular buffer: head (oldest), tail (next free), count; pointers wrap modulo DEPTH.
- in_ready = ~full. No same-cycle pass-through when full, even if a pop occurs.
- Push with in_waddr == 0: accepted (handshake completes), not stored; count unchanged.
- Push with in_waddr != 0: entry written at tail, tail++.
- we3 = ~empty; wa3/wd3 = head entry; all three forced to 0 when empty.
- Pop = we3 & ~stallW; head++. A pop matches exactly the cycle the register file commits the write.
- Simultaneous push (stored) and pop: count unchanged, both pointers advance.
- Ordering: writes drain strictly in push order; two entries to the same address both drain, the younger last.
- Lookup (combinational from state): q_hit = (q_ra != 0) & any valid entry with waddr == q_ra. q_data = wdata of the youngest such entry, 0 if no hit. The entry being popped this cycle still counts as pending.

## Timing
- Reset (async assert, sync-safe deassert): head = tail = 0, count = 0, empty = 1, full = 0, in_ready = 1, we3 = 0, wa3 = 0, wd3 = 0, q_hit = 0, q_data = 0.
- Push-to-write latency: an entry pushed in cycle N with an otherwise empty queue drives we3 in cycle N+1.
- With stallW held high, we3/wa3/wd3 stay constant on the head entry; the queue fills and in_ready drops at count == DEPTH.
- Throughput: one push and one pop per cycle sustained.
- Reset asserted mid-operation discards all entries immediately; no partial write is emitted after reset.

## Configuration
- WBQ_INPUT_FWD_EN defined: the lookup also checks the incoming write. If push & in_waddr == q_ra & q_ra != 0, then q_hit = 1 and q_data = in_wdata, with priority over queued entries.
- WBQ_INPUT_FWD_EN not defined: the lookup covers stored entries only; the incoming write is visible from the next cycle.

## Test plan
- Reset then idle: empty = 1, in_ready = 1, we3 = 0, count = 0. Assert rst mid-fill with count = 3: next sample shows all outputs at reset values.
- Single push (r5, 0xDEADBEEF), stallW = 0: next cycle we3 = 1, wa3 = 5, wd3 = 0xDEADBEEF. The cycle after: empty = 1.
- stallW = 1, push 5 entries with DEPTH = 4: 4 accepted, full = 1, in_ready = 0, head output unchanged. Release stallW: 4 writes drain in order over 4 cycles.
- Push r0 = 0x1234: handshake completes, count stays 0, no we3 pulse.
- Queue holds r7 = 0x11, then r7 = 0x22 (stallW = 1), q_ra = 7: q_hit = 1, q_data = 0x22. q_ra = 0: q_hit = 0.
- With WBQ_INPUT_FWD_EN, queue holds r3 = 0xA and push r3 = 0xB in the same cycle with q_ra = 3: q_data = 0xB. Without the macro: q_data = 0xA that cycle and 0xB the next.
